// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the core's load/store
// port. Accepts a request on MemReq, waits LATENCY cycles, then performs a
// byte/half/word access on an internal word array.
// Ports: clk, reset (async, active-high), MemReq/MemWrite/Funct3/Addr/
// WriteData in; ReadData (registered), MemReady (1-cycle pulse), MemError out.
// Optional: define DMEM_ALIGN_CHECK_EN for misalignment/illegal-Funct3 errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemError
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;
  logic [31:0]     store_val;
  logic            acc_err;
  logic            done;
  logic            mem_we;

  // Address bits above the word index alias into the array.
  logic            unused_addr;
  assign unused_addr = ^Addr[31:AW+2];

  assign idx  = addr_q[AW+1:2];
  assign word = mem_q[idx];
  assign done = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    byte_sel = word[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
    endcase
  end

  // Halfword lane uses Addr[1] only; Addr[0] is ignored
  // (a set Addr[0] is flagged separately when checking is on).
  assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'b0, byte_sel};
      3'b101:  load_val = {16'b0, half_sel};
      default: load_val = word;
    endcase
  end

  always_comb begin
    store_val = word;
    case (f3_q)
      3'b000: begin
        unique case (addr_q[1:0])
          2'd0: store_val[7:0]   = wdata_q[7:0];
          2'd1: store_val[15:8]  = wdata_q[7:0];
          2'd2: store_val[23:16] = wdata_q[7:0];
          2'd3: store_val[31:24] = wdata_q[7:0];
        endcase
      end
      3'b001: begin
        if (addr_q[1]) store_val[31:16] = wdata_q[15:0];
        else           store_val[15:0]  = wdata_q[15:0];
      end
      default: store_val = wdata_q;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Unsigned codes (1xx) are load-only, so a store with f3[2] set is illegal.
  always_comb begin
    acc_err = 1'b0;
    case (f3_q)
      3'b000, 3'b100: acc_err = wr_q && f3_q[2];
      3'b001, 3'b101: acc_err = addr_q[0] || (wr_q && f3_q[2]);
      3'b010:         acc_err = |addr_q[1:0];
      default:        acc_err = 1'b1;
    endcase
  end
`else
  assign acc_err = 1'b0;
`endif

  assign mem_we = done && wr_q && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (MemReq) begin
          wr_d    = MemWrite;
          f3_d    = Funct3;
          addr_d  = Addr[AW+1:0];
          wdata_d = WriteData;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RESP;
          err_d   = acc_err;
          if (acc_err)    rdata_d = '0;
          else if (!wr_q) rdata_d = load_val;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; an async reset forces IDLE so no write follows.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= store_val;
  end

  assign ReadData = rdata_q;
  assign MemReady = (state_q == RESP);
  assign MemError = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed scoreboard bench for dmem_responder.
// Expected responses come from a word-array model and are queued at issue.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int DW  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReq = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemError;

  dmem_responder #(
    .DEPTH_WORDS(DW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemReq(MemReq),
    .MemWrite(MemWrite),
    .Funct3(Funct3),
    .Addr(Addr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .MemReady(MemReady),
    .MemError(MemError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [DW];
  logic [31:0] last_rd = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: checks zeroed outputs under reset, pops the
  // scoreboard on each MemReady, flags overdue responses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (reset) begin
        check("rst_readdata", ReadData, 32'h0);
        check("rst_ready", {31'b0, MemReady}, 32'h0);
        check("rst_error", {31'b0, MemError}, 32'h0);
      end else if (MemReady) begin
        if (sb.size() == 0) begin
          check("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("readdata", ReadData, e.rd);
          check("memerror", {31'b0, MemError}, {31'b0, e.err});
          check("ready_cycle", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        check("ready_missing", cyc, e.cyc);
      end
    end
  end

  task automatic model(input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit e);
    int          idx;
    int          bs;
    int          hs;
    logic [31:0] cur;
    logic [31:0] msk;
    logic [7:0]  b;
    logic [15:0] h;
    idx = int'(a[7:2]);
    bs  = int'(a[1:0]) * 8;
    hs  = int'(a[1]) * 16;
    cur = mm[idx];
    b   = 8'(cur >> bs);
    h   = 16'(cur >> hs);
    e   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (f3 == 3'd1 || f3 == 3'd5) e = a[0];
    if (f3 == 3'd2) e = (a[1:0] != 2'd0);
    if (!w && (f3 == 3'd3 || f3 >= 3'd6)) e = 1'b1;
    if (w && f3 > 3'd2) e = 1'b1;
`endif
    rd = last_rd;
    if (e) begin
      rd = '0;
    end else if (w) begin
      if (f3 == 3'd0) begin
        msk = 32'hFF << bs;
        mm[idx] = (cur & ~msk) | ({24'b0, wd[7:0]} << bs);
      end else if (f3 == 3'd1) begin
        msk = 32'hFFFF << hs;
        mm[idx] = (cur & ~msk) | ({16'b0, wd[15:0]} << hs);
      end else begin
        mm[idx] = wd;
      end
    end else begin
      case (f3)
        3'd0:    rd = {{24{b[7]}}, b};
        3'd1:    rd = {{16{h[15]}}, h};
        3'd4:    rd = {24'b0, b};
        3'd5:    rd = {16'b0, h};
        default: rd = cur;
      endcase
    end
    last_rd = rd;
  endtask

  // b2b=1: called right after a MemReady, keep MemReq high.
  task automatic issue(input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit b2b);
    logic [31:0] rd;
    bit          e;
    exp_t        x;
    if (!b2b) begin
      MemReq = 1'b0;
      @(negedge clk);
    end
    MemReq    = 1'b1;
    MemWrite  = w;
    Funct3    = f3;
    Addr      = a;
    WriteData = wd;
    model(w, f3, a, wd, rd, e);
    x.rd  = rd;
    x.err = e;
    x.cyc = cyc + (b2b ? 2 : 1) + LAT;
    sb.push_back(x);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (MemReady) break;
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < DW; i++) mm[i] = '0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < DW; i++)
      issue(1'b1, 3'd2, 32'(i * 4), 32'h0, i != 0);

    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 3'd0, 32'h21, 32'h7F, 1'b0);
    issue(1'b0, 3'd0, 32'h21, 32'h0, 1'b0);
    issue(1'b1, 3'd0, 32'h22, 32'h80, 1'b0);
    issue(1'b0, 3'd0, 32'h22, 32'h0, 1'b0);
    issue(1'b0, 3'd4, 32'h22, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    issue(1'b1, 3'd1, 32'h32, 32'hBEEF, 1'b0);
    issue(1'b0, 3'd1, 32'h32, 32'h0, 1'b0);
    issue(1'b0, 3'd5, 32'h32, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 3'd2, 32'h13, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);

    issue(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5, 1'b0);
    issue(1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
    MemReq = 1'b0;
    @(negedge clk);
    MemReq    = 1'b1;
    MemWrite  = 1'b1;
    Funct3    = 3'd2;
    Addr      = 32'h40;
    WriteData = 32'h12345678;
    @(negedge clk);
    MemReq = 1'b0;
    #2 reset = 1'b1;
    last_rd = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    issue(1'b0, 3'd2, 32'h40, 32'h0, 1'b0);

    issue(1'b1, 3'd2, 32'h0, 32'h0BADF00D, 1'b0);
    issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h104, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && f3 == 3'd0) f3 = 3'd4;
      a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FE00);
      issue(1'($urandom_range(0, 1)), f3, a, $urandom,
            n != 0 && $urandom_range(0, 1) == 1);
    end
    MemReq = 1'b0;

    repeat (10) @(negedge clk);
    #3;
    if (sb.size() != 0)
      $display("FAIL scoreboard_left %0d expected 0", sb.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors + sb.size());
    $finish;
  end

endmodule
